// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL speed sequencer.
// Contents:
//   state_t      - sequencer FSM states
//   MGMT_*_W     - reconfiguration management port widths
//   REG_*        - reconfiguration register addresses
//   K_*_DEF      - default fractional-K words for native and 60Hz-adjusted speed
package pll_cfg_pkg;

  localparam int MGMT_ADDR_W = 6;
  localparam int MGMT_DATA_W = 32;

  localparam logic [MGMT_ADDR_W-1:0] REG_MODE   = 6'd0;
  localparam logic [MGMT_ADDR_W-1:0] REG_START  = 6'd2;
  localparam logic [MGMT_ADDR_W-1:0] REG_FRAC_K = 6'd7;

  localparam logic [MGMT_DATA_W-1:0] K_NATIVE_DEF = 32'd3639383488;
  localparam logic [MGMT_DATA_W-1:0] K_ADJUST_DEF = 32'd3262113561;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MODE    = 3'd1,
    W_FRAC    = 3'd2,
    W_START   = 3'd3,
    WAIT_DONE = 3'd4,
    WAIT_LOCK = 3'd5,
    DONE      = 3'd6
  } state_t;

endpackage

// File: rtl/pll_speed_sequencer_mgmt_writer.sv
// Single-write handshake engine for the PLL reconfiguration management port.
// Ports:
//   clk, reset        - reference clock, synchronous active-high reset
//   req               - a write is wanted with addr/data
//   addr, data        - captured when the strobe rises, held until acceptance
//   mgmt_waitrequest  - reconfig IP busy; strobe is held while high
//   mgmt_write        - registered write strobe
//   mgmt_address      - registered register address
//   mgmt_writedata    - registered register data
//   ack               - one cycle, on the cycle the IP accepts the write
// The strobe can only rise from a low cycle, so back-to-back requests always
// get at least one idle cycle between writes.
module mgmt_writer
  import pll_cfg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [MGMT_ADDR_W-1:0] addr,
  input  logic [MGMT_DATA_W-1:0] data,
  input  logic                   mgmt_waitrequest,
  output logic                   mgmt_write,
  output logic [MGMT_ADDR_W-1:0] mgmt_address,
  output logic [MGMT_DATA_W-1:0] mgmt_writedata,
  output logic                   ack
);

  // ack is the acceptance condition itself so the requester can step to its
  // next write on the same edge the strobe drops.
  assign ack = mgmt_write & ~mgmt_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) begin
      mgmt_write     <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else if (mgmt_write) begin
      if (!mgmt_waitrequest) begin
        mgmt_write <= 1'b0;
      end
    end else if (req) begin
      mgmt_write     <= 1'b1;
      mgmt_address   <= addr;
      mgmt_writedata <= data;
    end
  end

endmodule

// File: rtl/pll_speed_sequencer.sv
// Runtime PLL speed switch between native rate and the 60Hz-adjust underclock.
// Ports:
//   clk               - 50 MHz reference clock
//   reset             - synchronous active-high reset
//   speed_sel         - requested speed (0 native, 1 adjusted), asynchronous
//   pll_locked        - PLL lock, asynchronous
//   mgmt_waitrequest  - reconfig IP busy
//   mgmt_write        - management write strobe
//   mgmt_address      - management register address
//   mgmt_writedata    - management register data
//   busy              - sequence in progress
//   active_sel        - speed currently applied to the PLL
//   lock_err          - sticky lock-timeout flag, cleared only by reset
module pll_speed_sequencer
  import pll_cfg_pkg::*;
#(
  parameter logic [31:0] K_NATIVE     = K_NATIVE_DEF,
  parameter logic [31:0] K_ADJUST     = K_ADJUST_DEF,
  parameter logic [15:0] LOCK_SETTLE  = 16'd1024,
  parameter logic [23:0] LOCK_TIMEOUT = 24'd5_000_000
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   speed_sel,
  input  logic                   pll_locked,
  input  logic                   mgmt_waitrequest,
  output logic                   mgmt_write,
  output logic [MGMT_ADDR_W-1:0] mgmt_address,
  output logic [MGMT_DATA_W-1:0] mgmt_writedata,
  output logic                   busy,
  output logic                   active_sel,
  output logic                   lock_err
);

  state_t state, state_next;

  logic speed_sel_p0, speed_sel_p1, speed_sel_p2;
  logic lock_p0, lock_p1;

  logic        target;
  logic [15:0] lock_cnt;
  logic [23:0] to_cnt;

  logic                   wr_req;
  logic [MGMT_ADDR_W-1:0] wr_addr;
  logic [MGMT_DATA_W-1:0] wr_data;
  logic                   wr_ack;

  logic waiting;
  logic settle_done;
  logic timeout_fire;

  // Stage p0..p2: speed request synchronizer; p1==p2 marks a settled value.
  always_ff @(posedge clk) begin
    if (reset) begin
      speed_sel_p0 <= 1'b0;
      speed_sel_p1 <= 1'b0;
      speed_sel_p2 <= 1'b0;
    end else begin
      speed_sel_p0 <= speed_sel;
      speed_sel_p1 <= speed_sel_p0;
      speed_sel_p2 <= speed_sel_p1;
    end
  end

  // Stage p0..p1: lock synchronizer. Flushed outside WAIT_LOCK so a lock
  // indication left over from before the reconfiguration is never counted.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT_LOCK) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= pll_locked;
      lock_p1 <= lock_p0;
    end
  end

  assign waiting     = (state == WAIT_DONE) || (state == WAIT_LOCK);
  assign settle_done = (state == WAIT_LOCK) && lock_p1 &&
                       (lock_cnt == LOCK_SETTLE - 16'd1);
  // A settle that completes on the same cycle as the timeout wins.
  assign timeout_fire = waiting && !settle_done &&
                        (to_cnt == LOCK_TIMEOUT - 24'd1);

  always_comb begin
    state_next = state;
    wr_req     = 1'b0;
    wr_addr    = REG_MODE;
    wr_data    = '0;
    case (state)
      IDLE: begin
        if ((speed_sel_p1 == speed_sel_p2) && (speed_sel_p2 != active_sel)) begin
          state_next = W_MODE;
        end
      end
      W_MODE: begin
        wr_req  = 1'b1;
        wr_addr = REG_MODE;
        if (wr_ack) state_next = W_FRAC;
      end
      W_FRAC: begin
        wr_req  = 1'b1;
        wr_addr = REG_FRAC_K;
        wr_data = target ? K_ADJUST : K_NATIVE;
        if (wr_ack) state_next = W_START;
      end
      W_START: begin
        wr_req  = 1'b1;
        wr_addr = REG_START;
        if (wr_ack) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout_fire)           state_next = IDLE;
        else if (!mgmt_waitrequest) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (settle_done)       state_next = DONE;
        else if (timeout_fire) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      target     <= 1'b0;
      busy       <= 1'b0;
      active_sel <= 1'b0;
      lock_err   <= 1'b0;
      lock_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      if (state == IDLE && state_next == W_MODE) begin
        target <= speed_sel_p2;
      end
      if (state == DONE) begin
        active_sel <= target;
      end
      // On timeout the requested speed is recorded as applied so the
      // sequencer does not retry until the request changes again.
      if (timeout_fire) begin
        lock_err   <= 1'b1;
        active_sel <= target;
      end
      lock_cnt <= (state == WAIT_LOCK && lock_p1) ? lock_cnt + 16'd1 : 16'd0;
      to_cnt   <= (waiting && !timeout_fire) ? to_cnt + 24'd1 : 24'd0;
    end
  end

  mgmt_writer u_writer (
    .clk              (clk),
    .reset            (reset),
    .req              (wr_req),
    .addr             (wr_addr),
    .data             (wr_data),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .ack              (wr_ack)
  );

endmodule

// File: tb/tb_pll_speed_sequencer.sv
`timescale 1ns/1ps
module tb_pll_speed_sequencer;

  localparam int          LS = 20;
  localparam int          LT = 1000;
  localparam logic [31:0] KN = 32'd3639383488;
  localparam logic [31:0] KA = 32'd3262113561;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        speed_sel  = 1'b0;
  logic        pll_locked = 1'b1;
  logic        wr_force   = 1'b0;
  logic        hold_on    = 1'b0;
  logic        mgmt_waitrequest;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        busy;
  logic        active_sel;
  logic        lock_err;

  assign mgmt_waitrequest = wr_force | hold_on;

  pll_speed_sequencer #(
    .LOCK_SETTLE  (16'd20),
    .LOCK_TIMEOUT (24'd1000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .speed_sel        (speed_sel),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .busy             (busy),
    .active_sel       (active_sel),
    .lock_err         (lock_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        speed;
    int          frac_hold;
    logic        exp_active;
    logic [31:0] exp_k;
    int          exp_len;
  } vec_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   last_acc_cyc = 0;
  int   frac_len = 0;
  int   hold_req = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] k);
    exp_q.push_back('{6'd0, 32'd0});
    exp_q.push_back('{6'd7, k});
    exp_q.push_back('{6'd2, 32'd0});
  endtask

  task automatic wait_nacc(input int n, input int budget, input string nm);
    int k = 0;
    while (n_acc < n && k < budget) begin
      sample();
      k++;
    end
    if (n_acc < n) begin
      checks++;
      errors++;
      $display("FAIL %s writes got %0d want %0d within %0d cycles", nm, n_acc, n, budget);
    end
  endtask

  task automatic wait_active(input logic v, input int budget, input string nm, output int seen);
    int k = 0;
    seen = -1;
    while (active_sel !== v && k < budget) begin
      sample();
      k++;
    end
    if (active_sel === v) seen = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL %s active_sel got %0b want %0b within %0d cycles", nm, active_sel, v, budget);
    end
  endtask

  // Waitrequest stretcher: holds the IP busy for hold_req cycles on each new
  // register-7 strobe.
  initial begin
    int   left = 0;
    logic pw = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (left > 0) begin
        left--;
        if (left == 0) hold_on = 1'b0;
      end else if (hold_req > 0 && mgmt_write && !pw && mgmt_address == 6'd7) begin
        hold_on = 1'b1;
        left    = hold_req;
      end
      pw = mgmt_write;
    end
  end

  // Bus monitor and scoreboard.
  initial begin
    logic        acc;
    logic        prev_wr = 1'b0;
    logic        prev_acc = 1'b0;
    logic [5:0]  prev_addr = 6'd0;
    logic [31:0] prev_data = 32'd0;
    int          strobe_len = 0;
    wr_t         e;
    forever begin
      @(negedge clk);
      acc = mgmt_write && !mgmt_waitrequest;
      if (mon_en && !reset) begin
        if (prev_wr && !prev_acc)
          chk("strobe_hold", 64'({mgmt_write, mgmt_address, mgmt_writedata}),
              64'({1'b1, prev_addr, prev_data}));
        if (prev_acc) chk("write_gap", 64'(mgmt_write), 64'(0));
        if (acc) begin
          n_acc++;
          last_acc_cyc = cyc;
          if (mgmt_address == 6'd7) frac_len = strobe_len + 1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr %0d data %0d, none expected", mgmt_address, mgmt_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("write_addr", 64'(mgmt_address), 64'(e.addr));
            chk("write_data", 64'(mgmt_writedata), 64'(e.data));
          end
        end
      end
      strobe_len = mgmt_write ? strobe_len + 1 : 0;
      prev_wr   = mgmt_write;
      prev_acc  = acc;
      prev_addr = mgmt_address;
      prev_data = mgmt_writedata;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   base;
    int   acc_c;
    int   seen;
    int   k;

    vt[0] = '{1'b1, 0, 1'b1, KA, 1};
    vt[1] = '{1'b0, 0, 1'b0, KN, 1};
    vt[2] = '{1'b1, 7, 1'b1, KA, 8};
    vt[3] = '{1'b0, 3, 1'b0, KN, 4};

    // Reset values, then a long quiet run at native speed.
    repeat (3) @(posedge clk);
    sample();
    chk("rst_write", 64'(mgmt_write), 64'(0));
    chk("rst_addr", 64'(mgmt_address), 64'(0));
    chk("rst_data", 64'(mgmt_writedata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_active", 64'(active_sel), 64'(0));
    chk("rst_lock_err", 64'(lock_err), 64'(0));
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (10000) @(posedge clk);
    sample();
    chk("idle_writes", 64'(n_acc), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_active", 64'(active_sel), 64'(0));

    // Table-driven speed switches.
    for (int i = 0; i < 4; i++) begin
      base     = n_acc;
      hold_req = vt[i].frac_hold;
      push_seq(vt[i].exp_k);
      @(posedge clk);
      #1;
      speed_sel = vt[i].speed;
      repeat (4) sample();
      chk($sformatf("v%0d_busy_pre", i), 64'(busy), 64'(0));
      sample();
      chk($sformatf("v%0d_busy_trig", i), 64'(busy), 64'(1));
      chk($sformatf("v%0d_write_pre", i), 64'(mgmt_write), 64'(0));
      sample();
      chk($sformatf("v%0d_write_rise", i), 64'(mgmt_write), 64'(1));
      chk($sformatf("v%0d_first_addr", i), 64'(mgmt_address), 64'(0));
      wait_nacc(base + 3, 100, $sformatf("v%0d_start", i));
      acc_c = last_acc_cyc;
      wait_active(vt[i].exp_active, 200, $sformatf("v%0d_done", i), seen);
      chk($sformatf("v%0d_latency", i), 64'(seen - (acc_c + 1)), 64'(LS + 4));
      chk($sformatf("v%0d_frac_len", i), 64'(frac_len), 64'(vt[i].exp_len));
      repeat (5) sample();
      chk($sformatf("v%0d_busy_post", i), 64'(busy), 64'(0));
      chk($sformatf("v%0d_nwrites", i), 64'(n_acc - base), 64'(3));
      chk($sformatf("v%0d_queue", i), 64'(exp_q.size()), 64'(0));
      chk($sformatf("v%0d_active", i), 64'(active_sel), 64'(vt[i].exp_active));
      chk($sformatf("v%0d_lock_err", i), 64'(lock_err), 64'(0));
    end
    hold_req = 0;

    // Request toggles back mid-sequence: finish, then reprogram native.
    base = n_acc;
    push_seq(KA);
    push_seq(KN);
    @(posedge clk);
    #1;
    speed_sel = 1'b1;
    wait_nacc(base + 1, 50, "toggle_first_write");
    @(posedge clk);
    #1;
    speed_sel = 1'b0;
    wait_active(1'b1, 200, "toggle_first", seen);
    chk("toggle_first_active", 64'(active_sel), 64'(1));
    wait_active(1'b0, 200, "toggle_second", seen);
    repeat (5) sample();
    chk("toggle_active", 64'(active_sel), 64'(0));
    chk("toggle_nwrites", 64'(n_acc - base), 64'(6));
    chk("toggle_queue", 64'(exp_q.size()), 64'(0));
    chk("toggle_busy", 64'(busy), 64'(0));

    // Lock never arrives: timeout after LT cycles from start acceptance.
    base = n_acc;
    push_seq(KA);
    @(posedge clk);
    #1;
    pll_locked = 1'b0;
    speed_sel  = 1'b1;
    wait_nacc(base + 3, 100, "timeout_start");
    acc_c = last_acc_cyc;
    k = 0;
    while (lock_err !== 1'b1 && k < LT + 200) begin
      sample();
      k++;
    end
    chk("timeout_flag", 64'(lock_err), 64'(1));
    chk("timeout_cycles", 64'(cyc - (acc_c + 1)), 64'(LT));
    chk("timeout_active", 64'(active_sel), 64'(1));
    chk("timeout_busy", 64'(busy), 64'(0));
    pll_locked = 1'b1;
    repeat (100) sample();
    chk("timeout_no_retry", 64'(n_acc - base), 64'(3));
    chk("timeout_sticky", 64'(lock_err), 64'(1));

    // Reset with speed_sel held high: auto start, then reset in WAIT_DONE.
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    sample();
    chk("rst2_lock_err", 64'(lock_err), 64'(0));
    chk("rst2_active", 64'(active_sel), 64'(0));
    base = n_acc;
    push_seq(KA);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_nacc(base + 3, 100, "rst2_start");
    @(posedge clk);
    #1;
    wr_force = 1'b1;
    repeat (3) sample();
    chk("rst2_busy_wait", 64'(busy), 64'(1));
    chk("rst2_active_wait", 64'(active_sel), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    sample();
    chk("midrst_write", 64'(mgmt_write), 64'(0));
    chk("midrst_addr", 64'(mgmt_address), 64'(0));
    chk("midrst_data", 64'(mgmt_writedata), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_active", 64'(active_sel), 64'(0));
    wr_force = 1'b0;
    push_seq(KA);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_active(1'b1, 300, "rerun", seen);
    repeat (3) sample();
    chk("rerun_active", 64'(active_sel), 64'(1));
    chk("rerun_lock_err", 64'(lock_err), 64'(0));
    chk("rerun_nwrites", 64'(n_acc - base), 64'(6));
    chk("rerun_queue", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
